// File: rtl/branch_pc_select_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : branch_pc_select_pkg
// Brief  : Shared types and constants for the fetch-side branch PC selector.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
package branch_pc_select_pkg;

    localparam logic [31:0] C_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] C_PC_INC       = 32'd4;

    typedef struct packed {
        logic        valid;
        logic        pred;
        logic [31:0] target;
        logic [31:0] fallthrough;
    } branch_rec_t;

endpackage

`default_nettype wire

// File: rtl/branch_rec_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : branch_rec_pipe
// Brief  : Two-slot (EX, MEM) in-flight branch record pipe with stall/flush.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module branch_rec_pipe
    import branch_pc_select_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_capture,
    input  branch_rec_t i_new_rec,
    output branch_rec_t o_rec_mem
);

    branch_rec_t r_rec_ex;
    branch_rec_t r_rec_mem;

    // Flush beats stall and also drops the branch decoding in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rec_ex  <= '0;
            r_rec_mem <= '0;
        end else if (i_flush) begin
            r_rec_ex  <= '0;
            r_rec_mem <= '0;
        end else if (!i_stall) begin
            r_rec_mem <= r_rec_ex;
            r_rec_ex  <= i_capture ? i_new_rec : '0;
        end
    end

    assign o_rec_mem = r_rec_mem;

endmodule

`default_nettype wire

// File: rtl/branch_pc_select.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : branch_pc_select
// Brief  : Fetch PC owner; predicted-taken redirect, MEM-stage mispredict
//          recovery and saturating branch/mispredict counters.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module branch_pc_select
    import branch_pc_select_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = C_RESET_VECTOR,
    parameter int          COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_decode_sig,
    input  logic [31:0]        decode_pc,
    input  logic               prediction,
    input  logic [31:0]        branch_addr,
    input  logic               branch_mem_sig,
    input  logic               actual_branch_decision,
    output logic [31:0]        pc,
    output logic               mispredict,
    output logic [31:0]        recovery_addr,
    output logic               flush_fetch,
    output logic               flush_decode_ex,
    output logic               track_error,
    output logic [COUNT_W-1:0] branch_count,
    output logic [COUNT_W-1:0] mispredict_count
);

    branch_rec_t        w_new_rec;
    branch_rec_t        w_rec_mem;
    logic               w_mispredict;
    logic [31:0]        w_recovery_addr;
    logic [31:0]        w_pc_next;
    logic               w_branch_inc;
    logic               w_track_set;
    logic [31:0]        r_pc;
    logic               r_track_error;
    logic [COUNT_W-1:0] r_branch_count;
    logic [COUNT_W-1:0] r_mispredict_count;

    assign w_new_rec = '{valid:       1'b1,
                         pred:        prediction,
                         target:      branch_addr,
                         fallthrough: decode_pc + C_PC_INC};

    branch_rec_pipe u_rec_pipe (
        .clk       (clk),
        .reset     (reset),
        .i_stall   (stall),
        .i_flush   (w_mispredict),
        .i_capture (branch_decode_sig),
        .i_new_rec (w_new_rec),
        .o_rec_mem (w_rec_mem)
    );

    assign w_mispredict    = w_rec_mem.valid & branch_mem_sig
                           & (actual_branch_decision != w_rec_mem.pred);
    assign w_recovery_addr = !w_mispredict           ? 32'h0 :
                             actual_branch_decision  ? w_rec_mem.target :
                                                       w_rec_mem.fallthrough;

    always_comb begin
        w_pc_next = r_pc + C_PC_INC;
        if (w_mispredict)
            w_pc_next = w_recovery_addr;
        else if (stall)
            w_pc_next = r_pc;
        else if (branch_decode_sig && prediction)
            w_pc_next = branch_addr;
    end

    assign w_branch_inc = (w_rec_mem.valid & branch_mem_sig & ~stall) | w_mispredict;
    // Record pipe out of step with the MEM stage: orphan resolve or dropped record.
    assign w_track_set  = (branch_mem_sig & ~w_rec_mem.valid)
                        | (w_rec_mem.valid & ~stall & ~branch_mem_sig);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc               <= RESET_VECTOR;
            r_track_error      <= 1'b0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (w_track_set)
                r_track_error <= 1'b1;
            if (w_branch_inc && (r_branch_count != '1))
                r_branch_count <= r_branch_count + COUNT_W'(1);
            if (w_mispredict && (r_mispredict_count != '1))
                r_mispredict_count <= r_mispredict_count + COUNT_W'(1);
        end
    end

    assign pc               = r_pc;
    assign mispredict       = w_mispredict;
    assign recovery_addr    = w_recovery_addr;
    assign flush_fetch      = w_mispredict | (branch_decode_sig & prediction & ~stall);
    assign flush_decode_ex  = w_mispredict;
    assign track_error      = r_track_error;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

`default_nettype wire

// File: doc/branch_pc_select.md
Name: branch_pc_select

Overview:
- Fetch-side consumer of the branch predictor's outputs (prediction, branch_addr).
- Owns the architectural fetch PC and selects the next fetch address.
- Tracks every predicted branch through decode→EX→MEM in a 2-entry in-flight record pipe.
- At MEM, compares the prediction with the actual outcome, then raises a mispredict, the recovery address, and flushes; it also keeps saturating performance counters.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- COUNT_W, 16, width of the branch and mispredict performance counters.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline hold: PC and in-flight pipe keep their value.
- branch_decode_sig  in  1  decode-stage instruction is a conditional branch.
- decode_pc  in  32  PC of the decode-stage instruction.
- prediction  in  1  predictor taken/not-taken, valid while branch_decode_sig=1.
- branch_addr  in  32  predicted target (decode_pc+offset), valid while branch_decode_sig=1.
- branch_mem_sig  in  1  MEM-stage instruction is a branch being resolved.
- actual_branch_decision  in  1  resolved outcome, valid while branch_mem_sig=1.
- pc  out  32  current fetch PC.
- mispredict  out  1  combinational; MEM branch outcome differs from its recorded prediction.
- recovery_addr  out  32  combinational; correct next PC when mispredict=1.
- flush_fetch  out  1  squash the fetched instruction (predicted-taken redirect or mispredict).
- flush_decode_ex  out  1  squash the decode and EX instructions (= mispredict).
- track_error  out  1  sticky; set when the record pipe and branch_mem_sig disagree.
- branch_count  out  COUNT_W  resolved branches, saturating.
- mispredict_count  out  COUNT_W  mispredicts, saturating.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_VECTOR.
  - Both record slots invalid.
  - track_error, branch_count and mispredict_count = 0.
  - Because the slots are invalid, mispredict, flush_fetch and flush_decode_ex are 0 and recovery_addr=0.
  - Reset mid-operation discards all in-flight records.
- Record: {valid, pred, target=branch_addr, fallthrough=decode_pc+4}; the +4 add wraps modulo 2^32.
- Slots: rec_ex and rec_mem. The MEM-side check uses rec_mem.
- mispredict = rec_mem.valid & branch_mem_sig & (actual_branch_decision != rec_mem.pred).
- recovery_addr = actual_branch_decision ? rec_mem.target : rec_mem.fallthrough; 0 when mispredict=0.
- Next-PC priority on each posedge:
  1. mispredict → recovery_addr.
  2. stall → hold pc.
  3. branch_decode_sig & prediction → branch_addr.
  4. otherwise → pc+4, wrapping 32'hFFFF_FFFC → 0.
- Mispredict overrides stall: the redirect happens even when stall=1.
- Record pipe on posedge:
  - mispredict: rec_ex and rec_mem cleared (younger branches squashed); the decode branch in the same cycle is NOT captured.
  - else if stall: hold both slots.
  - else: rec_mem ← rec_ex; rec_ex ← new record if branch_decode_sig, else invalid.
- Latency:
  - Predicted-taken redirect: pc=branch_addr one cycle after the decode cycle.
  - Mispredict: pc=recovery_addr one cycle after the branch_mem_sig cycle.
- flush_fetch = mispredict | (branch_decode_sig & prediction & ~stall).
- flush_decode_ex = mispredict.
- Counters:
  - branch_count += 1 when rec_mem.valid & branch_mem_sig & ~stall, or when mispredict=1.
  - mispredict_count += 1 on mispredict.
  - Both saturate at all-ones and never wrap.
- track_error is set on either:
  - branch_mem_sig=1 with rec_mem invalid; no mispredict is raised and nothing is counted.
  - rec_mem valid, no stall, branch_mem_sig=0; the record is dropped.
  - track_error clears only on reset.

Decomposition:
- Shared package: branch_rec_t record type, RESET_VECTOR default, PC increment constant 4.
- One natural sub-module: branch_rec_pipe (2-slot record pipe with stall/flush).
- PC mux and counters stay in the top module.

Test Plan:
- Reset: assert reset mid-run with rec_ex valid → pc=RESET_VECTOR immediately; counters 0; mispredict=0 next cycle even with branch_mem_sig=1 (track_error=1).
- Predicted-taken: decode_pc=0x100, branch_addr=0x140, prediction=1 → flush_fetch=1, pc=0x140 next cycle; outcome taken two cycles later → mispredict=0, branch_count=1.
- Mispredict not-taken: decode_pc=0x200, prediction=1, target=0x280; actual=0 at MEM → mispredict=1, recovery_addr=0x204, pc=0x204 next cycle, mispredict_count=1, both slots cleared.
- Mispredict taken during stall: prediction=0, target=0x300; actual=1 at MEM with stall=1 → pc=0x300 next cycle.
- Back-to-back branches, first mispredicts: second branch in rec_ex is squashed and never resolved; decode branch in the same cycle is not captured.
- Saturation and wrap:
  - Preload-free run of 2^COUNT_W+3 resolved branches (COUNT_W=4 override) → branch_count holds 4'hF.
  - pc=0xFFFF_FFFC sequential → pc=0.
